// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory between an
// instruction-fetch port (read-only) and a data port (read/write).
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_owner_q, last_owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        grant_data;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_data   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the port that did not own the last access wins.
          grant_data = d_req && (!i_req || last_owner_q == OWN_I);
          if (grant_data) begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wr_d    = d_wr;
          end else begin
            owner_d = OWN_I;
            addr_d  = i_addr;
            wdata_d = '0;
            wr_d    = 1'b0;
          end
          last_owner_d = owner_d;
          cnt_d        = '0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (owner_q == OWN_D) d_rdata_d = mem_data_out;
          else                  i_rdata_d = mem_data_out;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign mem_enable  = (state_q == ACCESS);
  assign mem_wr      = mem_enable & wr_q;
  assign mem_addr    = mem_enable ? addr_q  : '0;
  assign mem_data_in = mem_enable ? wdata_q : '0;
  assign i_ack       = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ack       = (state_q == RESP) && (owner_q == OWN_D);
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LATENCY=4 and a LATENCY=1 instance, each compared
// every cycle against a transaction-level model, plus directed scenarios.
module tb_mem_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [N-1:0]          i_req, d_req, d_wr;
  logic [N-1:0][15:0]    i_addr, d_addr, d_wdata, mem_data_out;
  logic [N-1:0]          i_ack, d_ack, mem_enable, mem_wr, busy;
  logic [N-1:0][15:0]    i_rdata, d_rdata, mem_addr, mem_data_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int en_seen   [N];
  int dack_seen [N];
  int iack_seen [N];

  // Reference model: cycles elapsed since the grant (0 = idle).
  int          m_phase [N];
  logic        m_own   [N];
  logic        m_last  [N];
  logic        m_wr    [N];
  logic [15:0] m_addr  [N];
  logic [15:0] m_wdata [N];
  logic [15:0] m_ir    [N];
  logic [15:0] m_dr    [N];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return (a ^ 16'h3C3C) + {a[7:0], a[15:8]};
  endfunction

  function automatic int lat(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  assign mem_data_out[0] = mem_fn(mem_addr[0]);
  assign mem_data_out[1] = mem_fn(mem_addr[1]);

  mem_arbiter #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_wr(d_wr[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_enable(mem_enable[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0]), .busy(busy[0])
  );

  mem_arbiter #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_wr(d_wr[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_enable(mem_enable[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the arbitration rules at one rising edge, using pre-edge inputs.
  task automatic model_edge();
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        m_phase[g] = 0;
        m_last[g]  = 1'b0;
        m_ir[g]    = '0;
        m_dr[g]    = '0;
      end else if (m_phase[g] == 0) begin
        if (i_req[g] || d_req[g]) begin
          m_own[g]   = d_req[g] && !(i_req[g] && m_last[g]);
          m_last[g]  = m_own[g];
          m_addr[g]  = m_own[g] ? d_addr[g] : i_addr[g];
          m_wdata[g] = m_own[g] ? d_wdata[g] : 16'h0000;
          m_wr[g]    = m_own[g] && d_wr[g];
          m_phase[g] = 1;
        end
      end else if (m_phase[g] <= lat(g)) begin
        if (m_phase[g] == lat(g)) begin
          if (m_own[g]) m_dr[g] = mem_fn(m_addr[g]);
          else          m_ir[g] = mem_fn(m_addr[g]);
        end
        m_phase[g]++;
      end else begin
        m_phase[g] = 0;
      end
    end
  endtask

  function automatic logic [68:0] obs_vec(input int g);
    return {busy[g], i_ack[g], d_ack[g], mem_enable[g], mem_wr[g],
            mem_addr[g], mem_data_in[g], i_rdata[g], d_rdata[g]};
  endfunction

  function automatic logic [68:0] exp_vec(input int g);
    logic acc, resp;
    acc  = (m_phase[g] >= 1) && (m_phase[g] <= lat(g));
    resp = (m_phase[g] == lat(g) + 1);
    return {m_phase[g] != 0, resp && !m_own[g], resp && m_own[g], acc, acc && m_wr[g],
            acc ? m_addr[g] : 16'h0000, acc ? m_wdata[g] : 16'h0000, m_ir[g], m_dr[g]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("cycle%0d_u%0d", cyc, g), obs_vec(g), exp_vec(g));
      if (mem_enable[g]) en_seen[g]++;
      if (d_ack[g])      dack_seen[g]++;
      if (i_ack[g])      iack_seen[g]++;
    end
  endtask

  task automatic wait_ack(input int g, input bit is_d, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (is_d ? d_ack[g] : i_ack[g]) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    check($sformatf("ack_wait_u%0d_%s", g, is_d ? "d" : "i"), got, 1'b1);
  endtask

  task automatic clear_inputs();
    i_req = '0; d_req = '0; d_wr = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    int g0, t0, t1, t2;
    int order[$];
    int times[$];
    for (int g = 0; g < N; g++) begin
      m_phase[g] = 0; m_own[g] = 1'b0; m_last[g] = 1'b0; m_wr[g] = 1'b0;
      m_addr[g] = '0; m_wdata[g] = '0; m_ir[g] = '0; m_dr[g] = '0;
      en_seen[g] = 0; dack_seen[g] = 0; iack_seen[g] = 0;
    end
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_outputs_u0", obs_vec(0), '0);
    check("reset_outputs_u1", obs_vec(1), '0);

    // Single fetch of 0x0010.
    en_seen[0] = 0; dack_seen[0] = 0;
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    step();
    g0 = cyc;
    wait_ack(0, 1'b0, t0);
    check("read_rdata", i_rdata[0], 16'hA5A5);
    check("read_latency", t0 - g0, 4);
    i_req[0] = 1'b0;
    step();
    check("read_enable_cycles", en_seen[0], 4);
    check("read_no_dack", dack_seen[0], 0);

    // Data write.
    en_seen[0] = 0;
    d_req[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'h1234;
    step();
    check("write_mem_wr", mem_wr[0], 1'b1);
    check("write_mem_data_in", mem_data_in[0], 16'h1234);
    wait_ack(0, 1'b1, t0);
    clear_inputs();
    step();
    check("write_enable_cycles", en_seen[0], 4);
    check("write_busy_drop", busy[0], 1'b0);

    // Tie after reset, round-robin order and spacing.
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_req[0] = 1'b1; i_addr[0] = 16'h0500;
    d_req[0] = 1'b1; d_addr[0] = 16'h0600;
    for (int k = 0; k < 80 && order.size() < 4; k++) begin
      step();
      if (d_ack[0]) begin order.push_back(1); times.push_back(cyc); d_req[0] = 1'b0; end
      if (i_ack[0]) begin order.push_back(0); times.push_back(cyc); i_req[0] = 1'b0; end
      if (!i_req[0] && !d_req[0] && order.size() < 4) begin
        i_req[0] = 1'b1;
        d_req[0] = 1'b1;
      end
    end
    check("tie_ack_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) begin
      check($sformatf("tie_order_%0d", k), order[k], (k % 2 == 0) ? 1 : 0);
      if (k > 0) check($sformatf("tie_spacing_%0d", k), times[k] - times[k-1], 6);
    end
    clear_inputs();
    step();

    // Data request arrives while the fetch is in ACCESS.
    i_req[0] = 1'b1; i_addr[0] = 16'h0100;
    step();
    step();
    d_req[0] = 1'b1; d_addr[0] = 16'h0200;
    wait_ack(0, 1'b0, t1);
    check("during_access_irdata", i_rdata[0], mem_fn(16'h0100));
    i_req[0] = 1'b0;
    wait_ack(0, 1'b1, t2);
    check("during_access_spacing", t2 - t1, 6);
    check("during_access_drdata", d_rdata[0], mem_fn(16'h0200));
    clear_inputs();
    step();

    // Reset on the second ACCESS cycle of a data read.
    dack_seen[0] = 0;
    d_req[0] = 1'b1; d_addr[0] = 16'h0300;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_enable", mem_enable[0], 1'b0);
    check("rst_mid_drdata", d_rdata[0], 16'h0000);
    check("rst_mid_no_dack", dack_seen[0], 0);
    wait_ack(0, 1'b1, t0);
    check("rst_mid_fresh_drdata", d_rdata[0], mem_fn(16'h0300));
    check("rst_mid_single_ack", dack_seen[0], 1);
    clear_inputs();
    step();

    // LATENCY=1: back-to-back fetches of 0x0000 and 0x0002.
    i_req[1] = 1'b1; i_addr[1] = 16'h0000;
    step();
    g0 = cyc;
    wait_ack(1, 1'b0, t1);
    check("lat1_latency", t1 - g0, 1);
    check("lat1_rdata0", i_rdata[1], mem_fn(16'h0000));
    i_addr[1] = 16'h0002;
    wait_ack(1, 1'b0, t2);
    check("lat1_spacing", t2 - t1, 3);
    check("lat1_rdata2", i_rdata[1], mem_fn(16'h0002));
    clear_inputs();
    step();

    // Randomized requesters that hold until acked, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      for (int g = 0; g < N; g++) begin
        if (i_req[g]) begin
          if (i_ack[g]) begin
            if ($urandom_range(1) == 0) i_req[g] = 1'b0;
            else i_addr[g] = 16'($urandom);
          end
        end else if ($urandom_range(9) < 3) begin
          i_req[g] = 1'b1; i_addr[g] = 16'($urandom);
        end
        if (d_req[g]) begin
          if (d_ack[g]) begin
            if ($urandom_range(1) == 0) d_req[g] = 1'b0;
            else begin
              d_wr[g] = 1'($urandom_range(1)); d_addr[g] = 16'($urandom);
              d_wdata[g] = 16'($urandom);
            end
          end
        end else if ($urandom_range(9) < 3) begin
          d_req[g] = 1'b1; d_wr[g] = 1'($urandom_range(1));
          d_addr[g] = 16'($urandom); d_wdata[g] = 16'($urandom);
        end
      end
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;
    clear_inputs();
    for (int k = 0; k < 8; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
